gray_binary_seq_ctrl: RTL and testbench

//  Bit-serial Gray<->binary conversion controller. Accepts one WIDTH-bit word

---
 rtl/gray_binary_seq_ctrl_if.sv | 13 +
 rtl/gray_binary_seq_ctrl.sv | 61 ++++++
 tb/tb_gray_binary_seq_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_binary_seq_ctrl_if.sv
// gray_binary_seq_ctrl_if: request/result handshake bundle for the bit-serial Gray<->binary converter
// in_valid/in_ready/dir/data_in carry the word in; out_valid/out_ready/data_out carry the result out
interface gray_binary_seq_ctrl_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic             in_ready;
   logic             dir;
   logic [WIDTH-1:0] data_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   modport master (output in_valid, dir, data_in, out_ready, input in_ready, out_valid, data_out);
   modport slave  (input in_valid, dir, data_in, out_ready, output in_ready, out_valid, data_out);
endinterface

// File: rtl/gray_binary_seq_ctrl.sv
// gray_binary_seq_ctrl: MSB-first bit-serial Gray<->binary converter with handshakes and a handoff counter
// clk, rst_n (async active-low), clear (sync flush to IDLE), bus (slave: word in / result out),
// busy (SHIFT or DONE), conv_count (results handed off, wraps)
module gray_binary_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   gray_binary_seq_ctrl_if.slave bus,
   output logic                  busy,
   output logic [CNT_W-1:0]      conv_count
);
   localparam int IW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] word, dout;
   logic [IW-1:0]    idx;
   logic             dir_r, prev, bit_out, accept, handoff;
   assign accept  = state == IDLE && bus.in_valid;
   assign handoff = state == DONE && bus.out_ready;
   // One shared XOR: prev is the previous output bit (gray->binary) or previous input bit (binary->gray)
   assign bit_out = word[idx] ^ prev;
   assign bus.data_out = dout;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = clear ? IDLE :
                 accept ? SHIFT :
                 (state == SHIFT && idx == '0) ? DONE :
                 handoff ? IDLE : state;
   always_comb begin
      bus.in_ready  = state == IDLE;
      bus.out_valid = state == DONE;
      busy          = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         word       <= '0;
         dir_r      <= 1'b0;
         idx        <= '0;
         prev       <= 1'b0;
         dout       <= '0;
         conv_count <= '0;
      end else if (!clear) begin
         if (accept) begin
            word  <= bus.data_in;
            dir_r <= bus.dir;
            idx   <= IW'(WIDTH - 1);
            prev  <= 1'b0;
         end
         if (state == SHIFT) begin
            dout[idx] <= bit_out;
            prev      <= dir_r ? word[idx] : bit_out;
            idx       <= idx - IW'(1);
         end
         if (handoff) conv_count <= conv_count + CNT_W'(1);
      end
endmodule

// File: tb/tb_gray_binary_seq_ctrl.sv
// tb_gray_binary_seq_ctrl: table vectors, scoreboard and corner sequences for gray_binary_seq_ctrl
module tb_gray_binary_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       busy, busy2;
   logic [7:0] conv_count;
   logic [1:0] cnt2;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   logic [3:0] sb[$];
   logic [7:0] exp_cnt = '0;
   logic       hold_v = 1'b0;
   logic [3:0] hold_d = '0;
   typedef struct packed {logic dir; logic [3:0] din; logic [3:0] exp;} vec_t;
   vec_t tbl[8];

   gray_binary_seq_ctrl_if #(.WIDTH(4)) bus ();
   gray_binary_seq_ctrl_if #(.WIDTH(4)) bus2 ();
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.dir       = bus.dir;
   assign bus2.data_in   = bus.data_in;
   assign bus2.out_ready = bus.out_ready;

   gray_binary_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus), .busy(busy), .conv_count(conv_count));
   gray_binary_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus2), .busy(busy2), .conv_count(cnt2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] g2b(input logic [3:0] g);
      for (int i = 0; i < 4; i++) g2b[i] = ^(g >> i);
   endfunction

   function automatic logic [3:0] model(input logic [3:0] v, input logic d);
      return d ? (v ^ (v >> 1)) : g2b(v);
   endfunction

   task automatic send(input logic [3:0] d, input logic dr, input logic [3:0] e, output int acc);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      bus.dir      = dr;
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back(e);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   // out_ready driver: 0 = always ready, 1 = random stalls, 2 = held low
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.out_ready = rdy_mode == 1 ? 1'($urandom_range(0, 1)) : rdy_mode == 0;
      end
   end

   // Scoreboard: inputs change only just after a rising edge, so at the falling edge
   // the handshake signals show exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         exp_cnt = '0;
         hold_v  = 1'b0;
      end else begin
         chk("conv_count", 32'(conv_count), 32'(exp_cnt));
         chk("conv_count_w2", 32'(cnt2), 32'(exp_cnt[1:0]));
         if (hold_v) chk("stall_stable", 32'(bus.data_out), 32'(hold_d));
         hold_v = 1'b0;
         if (clear) sb.delete();
         else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("unexpected_result", 32'(bus.out_valid), 32'd0);
            else chk("data_out", 32'(bus.data_out), 32'(sb.pop_front()));
            exp_cnt = exp_cnt + 8'd1;
         end else if (bus.out_valid) begin
            hold_v = 1'b1;
            hold_d = bus.data_out;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1;
      tbl[0] = '{1'b0, 4'b0110, 4'b0100};
      tbl[1] = '{1'b0, 4'b1111, 4'b1010};
      tbl[2] = '{1'b1, 4'b1011, 4'b1110};
      tbl[3] = '{1'b1, 4'b0000, 4'b0000};
      tbl[4] = '{1'b0, 4'b1000, 4'b1111};
      tbl[5] = '{1'b1, 4'b1111, 4'b1000};
      tbl[6] = '{1'b0, 4'b0001, 4'b0001};
      tbl[7] = '{1'b1, 4'b0101, 4'b0111};
      bus.in_valid = 1'b0;
      bus.dir      = 1'b0;
      bus.data_in  = '0;
      #12;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_conv_count", 32'(conv_count), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // single word latency and handoff
      send(4'b0110, 1'b0, 4'b0100, a0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_data_out", 32'(bus.data_out), 32'b0100);
      chk("t1_in_ready_done", 32'(bus.in_ready), 32'd0);
      chk("t1_busy_done", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("t1_in_ready_back", 32'(bus.in_ready), 32'd1);
      chk("t1_out_valid_low", 32'(bus.out_valid), 32'd0);
      chk("t1_count", 32'(conv_count), 32'd1);
      // back-to-back words
      send(4'b1111, 1'b0, 4'b1010, a0);
      send(4'b1011, 1'b1, 4'b1110, a1);
      chk("t2_accept_spacing", 32'(a1 - a0), 32'd6);
      drain();
      chk("t2_count", 32'(conv_count), 32'd3);
      // vector table
      for (int i = 0; i < 8; i++) send(tbl[i].din, tbl[i].dir, tbl[i].exp, a0);
      drain();
      chk("tbl_count", 32'(conv_count), 32'd11);
      // inputs wiggled during SHIFT are ignored
      send(4'b0011, 1'b0, 4'b0010, a0);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = 4'($urandom_range(0, 15));
         bus.dir      = ~bus.dir;
         @(posedge clk); #1;
         chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
      drain();
      chk("t4_count", 32'(conv_count), 32'd12);
      // clear during SHIFT
      send(4'b1001, 1'b1, 4'b1101, a0);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t5a_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t5a_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5a_busy", 32'(busy), 32'd0);
      chk("t5a_count", 32'(conv_count), 32'd12);
      send(4'b1101, 1'b0, 4'b1001, a0);
      drain();
      chk("t5a_count_after", 32'(conv_count), 32'd13);
      // clear on the same edge as a handoff
      send(4'b0111, 1'b1, 4'b0100, a0);
      repeat (4) @(posedge clk);
      #1;
      chk("t5b_out_valid", 32'(bus.out_valid), 32'd1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t5b_out_valid_low", 32'(bus.out_valid), 32'd0);
      chk("t5b_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t5b_count", 32'(conv_count), 32'd13);
      send(4'b1010, 1'b1, 4'b1111, a0);
      drain();
      chk("t5b_count_after", 32'(conv_count), 32'd14);
      // exhaustive, both directions, random output stalls
      rdy_mode = 1;
      for (int d = 0; d < 2; d++)
         for (int v = 0; v < 16; v++) send(4'(v), 1'(d), model(4'(v), 1'(d)), a0);
      drain();
      rdy_mode = 0;
      @(posedge clk); #1;
      chk("t3_count", 32'(conv_count), 32'd46);
      // async reset mid-SHIFT
      send(4'b1100, 1'b0, 4'b1000, a0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_data_out", 32'(bus.data_out), 32'd0);
      chk("t6_count", 32'(conv_count), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send(4'(i + 3), 1'b1, model(4'(i + 3), 1'b1), a0);
      drain();
      chk("t6_count5", 32'(conv_count), 32'd5);
      chk("t6_wrap_w2", 32'(cnt2), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
